mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive cycles a pending fetch waits behind data before a forced fetch grant (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_req  input  1  instruction-fetch read request.
REQ-005 SHALL have port i_addr  input  12  fetch word line.
REQ-006 SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port i_rvalid  output  1  i_rdata valid.
REQ-008 SHALL have port i_rdata  output  32  fetch read data.
REQ-009 SHALL have port d_req  input  1  data-port request.
REQ-010 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-011 SHALL have port d_addr  input  12  data word line.
REQ-012 SHALL have port d_wdata  input  32  write data.
REQ-013 SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-014 SHALL have port d_rvalid  output  1  d_rdata valid (reads only).
REQ-015 SHALL have port d_rdata  output  32  data read data.
REQ-016 SHALL have ports mem_line out 12, mem_write_data out 32, mem_write out 1, mem_data in 32: single shared port to the word memory (combinational read, write on posedge).

Function
REQ-017 SHALL grant at most one requester per cycle; i_gnt and d_gnt are combinational from requests and internal state, never both 1.
REQ-018 SHALL, in a grant cycle, drive mem_line from the winner's address; mem_write = d_gnt & d_we; mem_write_data = d_wdata; otherwise mem_line, mem_write_data = 0, mem_write = 0.
REQ-019 SHALL register mem_data into the winner's rdata on the grant edge of a read; matching rvalid is 1 for exactly the following cycle (latency 1), else 0.
REQ-020 SHALL hold i_rdata/d_rdata stable until the next read for that port completes.
REQ-021 SHALL, for a data write, give no rvalid; d_gnt is the write acknowledge; memory updated on that edge.
REQ-022 Requester SHALL keep req/addr/we/wdata stable until gnt; arbiter does not buffer ungranted requests.
REQ-023 Fixed-priority mode: d_req wins over i_req, except when starve counter == STARVE_LIMIT, then i_req wins.
REQ-024 Starve counter (4 bits): increments each cycle i_req=1 and i_gnt=0, saturating at STARVE_LIMIT; clears on i_gnt or i_req=0.
REQ-025 Single requester SHALL be granted in the same cycle regardless of mode or counter.
REQ-026 Back-to-back grants to one port on consecutive cycles SHALL be supported (throughput 1 access/cycle).
REQ-027 Read of a line written in the previous cycle SHALL return the new data.

Reset
REQ-028 While rst=1: i_gnt=d_gnt=0, mem_write=0, mem_line=0, mem_write_data=0 regardless of requests; on the edge: i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, starve counter=0, last-winner=data.
REQ-029 rst asserted the cycle after a read grant SHALL suppress that rvalid; no partial write occurs (writes complete in the grant edge only).

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: on simultaneous requests, grant the port that did not win the most recent arbitration (1-bit last-winner register, updated on every grant); starve counter and STARVE_LIMIT unused.
REQ-031 MEM_ARB_RR_EN undefined: fixed priority with starvation limit per REQ-023/024; no last-winner register synthesized.

Verification
REQ-032 Preload line 5=0xDEADBEEF; i_req=1, i_addr=5 alone -> i_gnt same cycle, next cycle i_rvalid=1, i_rdata=0xDEADBEEF.
REQ-033 d write line 7=0x12345678, next cycle d read line 7 -> d_gnt both cycles, d_rvalid after read with 0x12345678, mem_write high only in write cycle.
REQ-034 Fixed mode, STARVE_LIMIT=4, i_req and d_req held high 10 cycles -> d_gnt cycles 0-3, i_gnt cycle 4, d_gnt 5-8, i_gnt 9.
REQ-035 MEM_ARB_RR_EN, both held high 6 cycles after reset -> grants i,d,i,d,i,d (data won last at reset).
REQ-036 rst=1 in cycle after a read grant, with i_req=d_req=1 -> no rvalid, no gnt, rdata=0, mem_write=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared word-memory port of mem_arbiter.
// slave: the arbiter's view; master: requesters plus the memory model.
interface mem_arbiter_if;
  logic        i_req;
  logic [11:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [11:0] mem_line;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_data;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_line, mem_write_data, mem_write
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_line, mem_write_data, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-cycle word memory, read latency 1.
// Default: data priority with fetch starvation limit; MEM_ARB_RR_EN selects alternating grant.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  logic        i_gnt;
  logic        d_gnt;
  logic        i_rvalid_q, i_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] i_rdata_q,  i_rdata_d;
  logic [31:0] d_rdata_q,  d_rdata_d;

`ifdef MEM_ARB_RR_EN
  // last_d_q = 1 when the data port won the most recent grant
  logic last_d_q, last_d_d;

  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    if (!rst) begin
      if (bus.i_req && bus.d_req) begin
        i_gnt = last_d_q;
        d_gnt = !last_d_q;
      end else begin
        i_gnt = bus.i_req;
        d_gnt = bus.d_req;
      end
    end
    last_d_d = last_d_q;
    if (i_gnt)      last_d_d = 1'b0;
    else if (d_gnt) last_d_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b1;
    else     last_d_q <= last_d_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       starved;

  always_comb begin
    starved = (starve_q == LIMIT);
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    if (!rst) begin
      d_gnt = bus.d_req && !(bus.i_req && starved);
      i_gnt = bus.i_req && !d_gnt;
    end
    starve_d = 4'd0;
    if (bus.i_req && !i_gnt)
      starve_d = starved ? starve_q : starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end
`endif

  always_comb begin
    bus.mem_line       = 12'd0;
    bus.mem_write_data = 32'd0;
    bus.mem_write      = 1'b0;
    if (i_gnt) begin
      bus.mem_line = bus.i_addr;
    end else if (d_gnt) begin
      bus.mem_line       = bus.d_addr;
      bus.mem_write_data = bus.d_wdata;
      bus.mem_write      = bus.d_we;
    end
  end

  // Read capture on the grant edge; rdata holds until that port's next read
  always_comb begin
    i_rvalid_d = i_gnt;
    i_rdata_d  = i_gnt ? bus.mem_data : i_rdata_q;
    d_rvalid_d = d_gnt && !bus.d_we;
    d_rdata_d  = (d_gnt && !bus.d_we) ? bus.mem_data : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Reset masks a response already in flight from the previous grant
  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rvalid_q && !rst;
  assign bus.d_rvalid = d_rvalid_q && !rst;
  assign bus.i_rdata  = rst ? 32'd0 : i_rdata_q;
  assign bus.d_rdata  = rst ? 32'd0 : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4K-word behavioural memory on the shared port.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem_model [0:4095];

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = mem_model[bus.mem_line];

  always @(posedge clk) begin
    if (bus.mem_write) mem_model[bus.mem_line] <= bus.mem_write_data;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = 12'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 12'd0;
    bus.d_wdata = 32'd0;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 12'd9;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'd3; bus.d_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL reset_i_gnt got=%b exp=0", bus.i_gnt); end
    checks++; if (bus.d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got=%b exp=0", bus.d_gnt); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write); end
    checks++; if (bus.mem_line !== 12'd0) begin errors++; $display("FAIL reset_mem_line got=%h exp=0", bus.mem_line); end
    checks++; if (bus.mem_write_data !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_write_data); end
    cyc();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", bus.i_rvalid, bus.d_rvalid); end
    checks++; if (bus.i_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.i_rdata, bus.d_rdata); end
    checks++; if (mem_model[3] !== 32'd0) begin errors++; $display("FAIL reset_no_write got=%h exp=0", mem_model[3]); end
  endtask

  task automatic test_fetch_read();
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 12'd5;
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got=%b%b exp=10", bus.i_gnt, bus.d_gnt); end
    checks++; if (bus.mem_line !== 12'd5 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL fetch_mem got=%h/%b exp=005/0", bus.mem_line, bus.mem_write); end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%b exp=1", bus.i_rvalid); end
    checks++; if (bus.i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got=%h exp=deadbeef", bus.i_rdata); end
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid got=%b exp=0", bus.d_rvalid); end
    checks++; if (bus.mem_line !== 12'd0) begin errors++; $display("FAIL idle_mem_line got=%h exp=0", bus.mem_line); end
    cyc();
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_drop got=%b exp=0", bus.i_rvalid); end
    checks++; if (bus.i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata_hold got=%h exp=deadbeef", bus.i_rdata); end
  endtask

  task automatic test_write_read();
    cyc();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'd7; bus.d_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got=%b%b exp=01", bus.i_gnt, bus.d_gnt); end
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_line !== 12'd7 || bus.mem_write_data !== 32'h12345678) begin
      errors++; $display("FAIL wr_mem got=%b/%h/%h exp=1/007/12345678", bus.mem_write, bus.mem_line, bus.mem_write_data); end
    cyc();
    bus.d_we = 1'b0; bus.d_wdata = 32'd0;
    @(negedge clk);
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", bus.d_gnt); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rd_mem_write got=%b exp=0", bus.mem_write); end
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", bus.d_rvalid); end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin
      errors++; $display("FAIL rd_data got=%b/%h exp=1/12345678", bus.d_rvalid, bus.d_rdata); end
    checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL rd_i_rvalid got=%b exp=0", bus.i_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [0:2];
    vals[0] = 32'h0000_1111; vals[1] = 32'h2222_0000; vals[2] = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) mem_model[10 + k] = vals[k];
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) begin bus.i_req = 1'b1; bus.i_addr = 12'(10 + k); end
      else idle_inputs();
      @(negedge clk);
      if (k < 3) begin
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", k, bus.i_gnt); end
      end
      if (k > 0) begin
        checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== vals[k-1]) begin
          errors++; $display("FAIL b2b_rdata[%0d] got=%b/%h exp=1/%h", k, bus.i_rvalid, bus.i_rdata, vals[k-1]); end
      end
    end
  endtask

  task automatic test_priority();
    cyc();
    rst = 1'b1;
    idle_inputs();
    cyc();
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 12'd5;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'd7;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 6; k++) begin
      logic exp_i;
      if (k > 0) cyc();
      exp_i = (k % 2 == 0);
      @(negedge clk);
      checks++; if (bus.i_gnt !== exp_i || bus.d_gnt !== !exp_i) begin
        errors++; $display("FAIL rr_grant[%0d] got=%b%b exp=%b%b", k, bus.i_gnt, bus.d_gnt, exp_i, !exp_i); end
    end
`else
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      if (k > 0) cyc();
      exp_i = (k == 4) || (k == 9);
      @(negedge clk);
      checks++; if (bus.i_gnt !== exp_i || bus.d_gnt !== !exp_i) begin
        errors++; $display("FAIL prio_grant[%0d] got=%b%b exp=%b%b", k, bus.i_gnt, bus.d_gnt, exp_i, !exp_i); end
    end
`endif
    cyc();
    idle_inputs();
  endtask

  task automatic test_starve_clear();
`ifndef MEM_ARB_RR_EN
    // three losses, one idle fetch cycle, then a fresh four-cycle wait
    for (int k = 0; k < 9; k++) begin
      logic exp_i;
      cyc();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'd7;
      bus.i_req = (k != 3); bus.i_addr = 12'd5;
      exp_i = (k == 8);
      @(negedge clk);
      checks++; if (bus.i_gnt !== exp_i || bus.d_gnt !== !exp_i) begin
        errors++; $display("FAIL starve_clear[%0d] got=%b%b exp=%b%b", k, bus.i_gnt, bus.d_gnt, exp_i, !exp_i); end
    end
    cyc();
    idle_inputs();
`endif
  endtask

  task automatic test_rst_after_read();
    mem_model[20] = 32'h0BADF00D;
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 12'd5;
    @(negedge clk);
    checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL rar_gnt got=%b exp=1", bus.i_gnt); end
    cyc();
    rst = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'd20; bus.d_wdata = 32'h11112222;
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL rar_rvalid got=%b%b exp=00", bus.i_rvalid, bus.d_rvalid); end
    checks++; if (bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin errors++; $display("FAIL rar_gnt_rst got=%b%b exp=00", bus.i_gnt, bus.d_gnt); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rar_mem_write got=%b exp=0", bus.mem_write); end
    checks++; if (bus.i_rdata !== 32'd0) begin errors++; $display("FAIL rar_rdata got=%h exp=0", bus.i_rdata); end
    cyc();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'd0) begin errors++; $display("FAIL rar_after got=%b/%h exp=0/0", bus.i_rvalid, bus.i_rdata); end
    checks++; if (mem_model[20] !== 32'h0BADF00D) begin errors++; $display("FAIL rar_no_write got=%h exp=0badf00d", mem_model[20]); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem_model[a] = 32'd0;
    mem_model[5] = 32'hDEADBEEF;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_write_read();
    test_back_to_back();
    test_priority();
    test_starve_clear();
    test_rst_after_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
